// File: rtl/board_writer_if.sv
// Move request/board bus between the game controller side and board_writer.
// master drives moves and game status; slave (board_writer) owns the board.
interface board_writer_if;
    logic        move_valid;
    logic [3:0]  move_idx;
    logic        new_game;
    logic        game_over;
    logic        move_ready;
    logic        move_reject;
    logic [17:0] tiles;
    logic        turn;
    logic [3:0]  move_count;
    logic        board_locked;

    modport master (
        output move_valid, move_idx, new_game, game_over,
        input  move_ready, move_reject, tiles, turn, move_count, board_locked
    );

    modport slave (
        input  move_valid, move_idx, new_game, game_over,
        output move_ready, move_reject, tiles, turn, move_count, board_locked
    );
endinterface

// File: rtl/board_writer.sv
// Write side of the tic-tac-toe tiles bus: validates moves, alternates players,
// waits for game_play to evaluate each write and freezes the board when finished.
module board_writer #(
    parameter int SETTLE_CYCLES = 2,
    parameter bit FIRST_PLAYER  = 1'b0
) (
    input logic          clk,
    input logic          reset,
    board_writer_if.slave bus
);

    typedef enum logic [1:0] {WAIT_MOVE, SETTLE, DONE} state_t;

    state_t      state, state_n;
    logic [17:0] tiles_q, tiles_n;
    logic        turn_q, turn_n;
    logic [3:0]  count_q, count_n;
    logic [3:0]  settle_q, settle_n;
    logic        reject_q, reject_n;
    logic        occupied;
    logic [1:0]  mark;

    assign mark = turn_q ? 2'b10 : 2'b01;

    always_comb begin
        occupied = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (bus.move_idx == 4'(i)) occupied = (tiles_q[2*i +: 2] != 2'b00);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= WAIT_MOVE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tiles_q  <= '0;
            turn_q   <= FIRST_PLAYER;
            count_q  <= '0;
            settle_q <= '0;
            reject_q <= 1'b0;
        end else begin
            tiles_q  <= tiles_n;
            turn_q   <= turn_n;
            count_q  <= count_n;
            settle_q <= settle_n;
            reject_q <= reject_n;
        end
    end

    always_comb begin
        state_n  = state;
        tiles_n  = tiles_q;
        turn_n   = turn_q;
        count_n  = count_q;
        settle_n = settle_q;
        reject_n = 1'b0;
        if (bus.new_game) begin
            // new_game wins over everything, including a move in the same cycle
            state_n  = WAIT_MOVE;
            tiles_n  = '0;
            turn_n   = FIRST_PLAYER;
            count_n  = '0;
            settle_n = '0;
        end else begin
            case (state)
                WAIT_MOVE: begin
                    if (bus.move_valid) begin
                        if (bus.move_idx > 4'd8 || occupied) begin
                            reject_n = 1'b1;
                        end else begin
                            for (int i = 0; i < 9; i++) begin
                                if (bus.move_idx == 4'(i)) tiles_n[2*i +: 2] = mark;
                            end
                            count_n  = count_q + 4'd1;
                            settle_n = 4'(SETTLE_CYCLES - 1);
                            state_n  = SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_q != 4'd0) begin
                        settle_n = settle_q - 4'd1;
                    end else if (bus.game_over || count_q == 4'd9) begin
                        // turn stays with the player who made the final move
                        state_n = DONE;
                    end else begin
                        turn_n  = ~turn_q;
                        state_n = WAIT_MOVE;
                    end
                end
                DONE:    state_n = DONE;
                default: state_n = WAIT_MOVE;
            endcase
        end
    end

    assign bus.move_ready   = (state == WAIT_MOVE);
    assign bus.board_locked = (state == DONE);
    assign bus.move_reject  = reject_q;
    assign bus.tiles        = tiles_q;
    assign bus.turn         = turn_q;
    assign bus.move_count   = count_q;

endmodule
